// File: rtl/program_counter_pkg.sv
// Purpose: shared next-PC select encoding and widths for the fetch-stage program counter.
// The enum values match the `PC_MUX_* codes the decoder/control unit uses:
//   PcMuxPcPlus4 = 2'b00 (`PC_MUX_PC_PLUS4)
//   PcMuxAluOut  = 2'b01 (`PC_MUX_ALU_OUT)
//   PcMuxPcAdder = 2'b10 (`PC_MUX_PC_ADDER)
//   2'b11 is reserved and decodes as PC+step.
package program_counter_pkg;

  localparam int unsigned PcMuxW = 2;

  typedef enum logic [PcMuxW-1:0] {
    PcMuxPcPlus4 = 2'b00,
    PcMuxAluOut  = 2'b01,
    PcMuxPcAdder = 2'b10,
    PcMuxRsvd    = 2'b11
  } pc_mux_e;

endpackage

// File: rtl/program_counter_pc_next_mux.sv
// Purpose: combinational next-PC selection for the fetch stage.
// Ports:
//   branch          - 2-bit select code (pc_mux_e encoding)
//   pc              - current PC
//   alu_result      - JALR-style target from the ALU
//   pc_adder_result - branch/JAL target from the PC-relative adder
//   pc_next         - selected candidate; targets pass through unmodified
module program_counter_pc_next_mux
  import program_counter_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned PC_STEP = 4
) (
  input  logic [PcMuxW-1:0] branch,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [XLEN-1:0]   pc_adder_result,
  output logic [XLEN-1:0]   pc_next
);

  logic [XLEN-1:0] pc_plus_step;

  // Modulo 2^XLEN; carry out is deliberately dropped.
  assign pc_plus_step = pc + XLEN'(PC_STEP);

  always_comb begin
    pc_next = pc_plus_step;
    unique case (pc_mux_e'(branch))
      PcMuxPcPlus4: pc_next = pc_plus_step;
      PcMuxAluOut:  pc_next = alu_result;
      PcMuxPcAdder: pc_next = pc_adder_result;
      PcMuxRsvd:    pc_next = pc_plus_step;
      default:      pc_next = pc_plus_step;
    endcase
  end

endmodule

// File: rtl/program_counter.sv
// Purpose: RV32 fetch-stage program counter. Holds the current instruction address and, on
// each enabled rising edge, loads the candidate picked by the select code.
// Ports:
//   clk             - clock, all state updates on rising edge
//   rst             - synchronous active-high reset to RESET_VECTOR, overrides en
//   en              - update enable; 0 holds pc (stall)
//   branch          - next-PC select code
//   alu_result      - candidate target from ALU
//   pc_adder_result - candidate target from PC-relative adder
//   pc              - registered current PC
//   pc_next         - combinational selected next PC (independent of en and rst)
module program_counter
  import program_counter_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     PC_STEP      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [PcMuxW-1:0] branch,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [XLEN-1:0]   pc_adder_result,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   pc_next
);

  logic [XLEN-1:0] pc_d, pc_q;

  program_counter_pc_next_mux #(
    .XLEN    (XLEN),
    .PC_STEP (PC_STEP)
  ) u_pc_next_mux (
    .branch          (branch),
    .pc              (pc_q),
    .alu_result      (alu_result),
    .pc_adder_result (pc_adder_result),
    .pc_next         (pc_next)
  );

  always_comb begin
    pc_d = pc_q;
    if (rst) begin
      pc_d = RESET_VECTOR;
    end else if (en) begin
      pc_d = pc_next;
    end
  end

  always_ff @(posedge clk) begin
    pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter. Inputs change on the falling edge; pc_next is checked
// combinationally before the rising edge, and the expected pc for that edge is queued and
// compared one time unit after the edge.
module tb_program_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  branch = 2'b00;
  logic [31:0] alu_result = '0;
  logic [31:0] pc_adder_result = '0;
  logic [31:0] pc;
  logic [31:0] pc_next;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [31:0] exp_q[$];

  program_counter #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0),
    .PC_STEP      (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .branch          (branch),
    .alu_result      (alu_result),
    .pc_adder_result (pc_adder_result),
    .pc              (pc),
    .pc_next         (pc_next)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, check pc_next before the edge (unless skip_next), queue the
  // expected pc for after the edge, then pop and compare it.
  task automatic step(input string tag, input logic r, input logic e, input logic [1:0] b,
                      input logic [31:0] a, input logic [31:0] p, input logic skip_next,
                      input logic [31:0] exp_next, input logic [31:0] exp_pc);
    logic [31:0] want;
    @(negedge clk);
    rst = r;
    en = e;
    branch = b;
    alu_result = a;
    pc_adder_result = p;
    #1;
    if (!skip_next) begin
      vectors++;
      assert (pc_next === exp_next) else begin
        miscompares++;
        $error("FAIL %s pc_next: got %h want %h", tag, pc_next, exp_next);
      end
    end
    exp_q.push_back(exp_pc);
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    vectors++;
    assert (pc === want) else begin
      miscompares++;
      $error("FAIL %s pc: got %h want %h", tag, pc, want);
    end
  endtask

  initial begin
    // Reset; pc_next before the first reset depends on an undefined pc, so skip it.
    step("reset",       1'b1, 1'b0, 2'b00, 32'h0,         32'h0,    1'b1, 32'h0,  32'h0);
    step("seq_first",   1'b0, 1'b1, 2'b00, 32'h0,         32'h0,    1'b0, 32'h4,  32'h4);
    step("alu_sel",     1'b0, 1'b1, 2'b01, 32'h1000,      32'h0,    1'b0, 32'h1000, 32'h1000);
    step("adder_sel",   1'b0, 1'b1, 2'b10, 32'h1000,      32'h2000, 1'b0, 32'h2000, 32'h2000);
    step("stall_1",     1'b0, 1'b0, 2'b00, 32'h0,         32'h0,    1'b0, 32'h2004, 32'h2000);
    step("stall_2",     1'b0, 1'b0, 2'b00, 32'h0,         32'h0,    1'b0, 32'h2004, 32'h2000);
    step("unstall",     1'b0, 1'b1, 2'b00, 32'h0,         32'h0,    1'b0, 32'h2004, 32'h2004);
    step("reserved",    1'b0, 1'b1, 2'b11, 32'h5555,      32'h6666, 1'b0, 32'h2008, 32'h2008);
    step("force_top",   1'b0, 1'b1, 2'b01, 32'hFFFF_FFFC, 32'h0,    1'b0, 32'hFFFF_FFFC,
         32'hFFFF_FFFC);
    step("wrap",        1'b0, 1'b1, 2'b00, 32'h0,         32'h0,    1'b0, 32'h0,  32'h0);
    step("reserved_2",  1'b0, 1'b1, 2'b11, 32'h0,         32'h0,    1'b0, 32'h4,  32'h4);
    // pc_next ignores rst; pc still takes the reset vector.
    step("rst_over_en", 1'b1, 1'b1, 2'b01, 32'h1234,      32'h0,    1'b0, 32'h1234, 32'h0);
    step("post_rst",    1'b0, 1'b1, 2'b00, 32'h0,         32'h0,    1'b0, 32'h4,  32'h4);
    // Unaligned target passes through untouched.
    step("unaligned",   1'b0, 1'b1, 2'b10, 32'h0,         32'hABD,  1'b0, 32'hABD, 32'hABD);
    step("seq_unalign", 1'b0, 1'b1, 2'b00, 32'h0,         32'h0,    1'b0, 32'hAC1, 32'hAC1);
    step("rst_no_en",   1'b1, 1'b0, 2'b10, 32'h0,         32'h7770, 1'b0, 32'h7770, 32'h0);
    step("hold_after",  1'b0, 1'b0, 2'b01, 32'h8888,      32'h0,    1'b0, 32'h8888, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
